operand_packer_4x4: RTL and testbench

OPERAND_PACKER_4X4 -- requirements
Module: operand_packer_4x4

---
 rtl/operand_packer_4x4.sv | 155 +++++++++++++++
 tb/tb_operand_packer_4x4.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_packer_4x4.sv
// Packs a stream of IFM/weight byte pairs into 4-lane operand groups for the
// 4-lane multiplier, padding short final groups and counting groups per vector.
module operand_packer_4x4 #(
    parameter logic [7:0] PAD_VALUE = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_ifm,
    input  logic [7:0]  in_wgt,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  ifm_1,
    output logic [7:0]  ifm_2,
    output logic [7:0]  ifm_3,
    output logic [7:0]  ifm_4,
    output logic [7:0]  wgt_1,
    output logic [7:0]  wgt_2,
    output logic [7:0]  wgt_3,
    output logic [7:0]  wgt_4,
    output logic [3:0]  lane_mask,
    output logic        out_last,
    output logic [15:0] group_cnt
);
    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never waits on ready, and payload is stable while valid=1.

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [1:0]  fill_q;
    logic [7:0]  pk_ifm [4];
    logic [7:0]  pk_wgt [4];
    logic [3:0]  pk_mask;
    logic        pk_last;

    logic [7:0]  g_ifm [4];
    logic [7:0]  g_wgt [4];
    logic [3:0]  g_mask;

    logic [7:0]  o_ifm [4];
    logic [7:0]  o_wgt [4];
    logic [3:0]  o_mask;
    logic        o_last;
    logic        o_valid;
    logic [15:0] cnt_q;

    logic accept, complete, out_xfer, out_free;

    assign in_ready = (state_q == FILL);
    assign accept   = in_valid && in_ready;
    assign complete = accept && ((fill_q == 2'd3) || in_last);
    assign out_xfer = o_valid && out_ready;
    assign out_free = !o_valid || out_ready;

    // Completed group as it would look this edge: written lanes, the incoming
    // pair in the current lane, and padding above it.
    always_comb begin
        g_mask = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            g_ifm[k] = PAD_VALUE;
            g_wgt[k] = PAD_VALUE;
            if (k < int'(fill_q)) begin
                g_ifm[k]  = pk_ifm[k];
                g_wgt[k]  = pk_wgt[k];
                g_mask[k] = 1'b1;
            end else if (k == int'(fill_q)) begin
                g_ifm[k]  = in_ifm;
                g_wgt[k]  = in_wgt;
                g_mask[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (complete && !out_free) state_d = HOLD;
            HOLD:    if (out_free)              state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_q  <= 2'd0;
            pk_mask <= 4'b0000;
            pk_last <= 1'b0;
            o_mask  <= 4'b0000;
            o_last  <= 1'b0;
            o_valid <= 1'b0;
            cnt_q   <= 16'd0;
            for (int k = 0; k < 4; k++) begin
                pk_ifm[k] <= 8'd0;
                pk_wgt[k] <= 8'd0;
                o_ifm[k]  <= 8'd0;
                o_wgt[k]  <= 8'd0;
            end
        end else begin
            if (out_xfer) cnt_q <= o_last ? 16'd0 : cnt_q + 16'd1;

            // A held group has priority; FILL cannot complete while in HOLD.
            if (state_q == HOLD && out_free) begin
                o_ifm   <= pk_ifm;
                o_wgt   <= pk_wgt;
                o_mask  <= pk_mask;
                o_last  <= pk_last;
                o_valid <= 1'b1;
            end else if (complete && out_free) begin
                o_ifm   <= g_ifm;
                o_wgt   <= g_wgt;
                o_mask  <= g_mask;
                o_last  <= in_last;
                o_valid <= 1'b1;
            end else if (out_xfer) begin
                o_valid <= 1'b0;
            end

            if (accept && !complete) begin
                pk_ifm[fill_q] <= in_ifm;
                pk_wgt[fill_q] <= in_wgt;
                fill_q         <= fill_q + 2'd1;
            end else if (complete) begin
                fill_q <= 2'd0;
                if (!out_free) begin
                    pk_ifm  <= g_ifm;
                    pk_wgt  <= g_wgt;
                    pk_mask <= g_mask;
                    pk_last <= in_last;
                end
            end
        end
    end

    assign out_valid = o_valid;
    assign ifm_1     = o_ifm[0];
    assign ifm_2     = o_ifm[1];
    assign ifm_3     = o_ifm[2];
    assign ifm_4     = o_ifm[3];
    assign wgt_1     = o_wgt[0];
    assign wgt_2     = o_wgt[1];
    assign wgt_3     = o_wgt[2];
    assign wgt_4     = o_wgt[3];
    assign lane_mask = o_mask;
    assign out_last  = o_last;
    assign group_cnt = cnt_q;

endmodule

// File: tb/tb_operand_packer_4x4.sv
// Directed and random stimulus for operand_packer_4x4; output groups are
// checked against an expected queue by a monitor running on the falling edge.
module tb_operand_packer_4x4;
    localparam logic [7:0] PAD = 8'hA5;
    localparam int W = 85;

    logic        clk, rst_n;
    logic        in_valid, in_ready, in_last;
    logic [7:0]  in_ifm, in_wgt;
    logic        out_valid, out_ready, out_last;
    logic [7:0]  ifm_1, ifm_2, ifm_3, ifm_4;
    logic [7:0]  wgt_1, wgt_2, wgt_3, wgt_4;
    logic [3:0]  lane_mask;
    logic [15:0] group_cnt;

    operand_packer_4x4 #(.PAD_VALUE(PAD)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ifm(in_ifm), .in_wgt(in_wgt), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .ifm_1(ifm_1), .ifm_2(ifm_2), .ifm_3(ifm_3), .ifm_4(ifm_4),
        .wgt_1(wgt_1), .wgt_2(wgt_2), .wgt_3(wgt_3), .wgt_4(wgt_4),
        .lane_mask(lane_mask), .out_last(out_last), .group_cnt(group_cnt)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs;
    bit use_model = 0;
    bit rand_ord  = 0;

    logic [7:0]  m_ifm [4];
    logic [7:0]  m_wgt [4];
    int          m_idx = 0;
    logic [15:0] m_cnt = 16'd0;

    assign obs = {ifm_1, ifm_2, ifm_3, ifm_4, wgt_1, wgt_2, wgt_3, wgt_4,
                  lane_mask, out_last, group_cnt};

    function automatic logic [W-1:0] grp(input logic [31:0] ifms, input logic [31:0] wgts,
                                         input logic [3:0] m, input logic l, input logic [15:0] c);
        return {ifms, wgts, m, l, c};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // reference packing model used for the random stream
    task automatic model_accept(input logic [7:0] i, input logic [7:0] w, input logic l);
        logic [3:0] m;
        m_ifm[m_idx] = i;
        m_wgt[m_idx] = w;
        if (m_idx == 3 || l) begin
            m = 4'b0000;
            for (int k = 0; k < 4; k++) begin
                if (k <= m_idx) m[k] = 1'b1;
                else begin
                    m_ifm[k] = PAD;
                    m_wgt[k] = PAD;
                end
            end
            exp_q.push_back(grp({m_ifm[0], m_ifm[1], m_ifm[2], m_ifm[3]},
                                {m_wgt[0], m_wgt[1], m_wgt[2], m_wgt[3]}, m, l, m_cnt));
            m_cnt = l ? 16'd0 : m_cnt + 16'd1;
            m_idx = 0;
        end else begin
            m_idx++;
        end
    endtask

    // driver: called just after a rising edge, returns just after the accepting edge
    task automatic send_pair(input logic [7:0] i, input logic [7:0] w, input logic l,
                             output int waited);
        bit ok;
        waited = 0;
        in_valid = 1'b1;
        in_ifm = i;
        in_wgt = w;
        in_last = l;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            waited++;
            if (waited > 50) break;
            if (rand_ord) out_ready = 1'($urandom_range(0, 1));
        end
        checks++;
        assert (waited <= 50) else begin
            errors++;
            $error("FAIL send_timeout observed=%0d expected<=50", waited);
        end
        if (ok && use_model) model_accept(i, w, l);
        in_valid = 1'b0;
        in_ifm = 8'($urandom);
        in_wgt = 8'($urandom);
        in_last = 1'($urandom);
        if (rand_ord) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_drained"}, W'(exp_q.size()), W'(0));
        @(negedge clk);
        check({tag, "_idle"}, W'(out_valid), W'(0));
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    initial begin
        logic [W-1:0] prev;
        bit stall;
        stall = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 0;
            end else begin
                if (stall) begin
                    check("stall_payload", obs, prev);
                    check("stall_valid", W'(out_valid), W'(1));
                end
                if (out_valid && out_ready) begin
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_group observed=%h expected=none", obs);
                    end
                    if (exp_q.size() != 0) check("group", obs, exp_q.pop_front());
                end
                stall = out_valid && !out_ready;
                prev = obs;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [W-1:0] g0, g1;
        logic l;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_ifm = 8'd0;
        in_wgt = 8'd0;
        in_last = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_payload", obs, W'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1;

        // eight pairs, two full groups, no back-pressure
        out_ready = 1'b1;
        exp_q.push_back(grp({8'd1, 8'd2, 8'd3, 8'd4}, 32'h10111213, 4'b1111, 1'b0, 16'd0));
        exp_q.push_back(grp({8'd5, 8'd6, 8'd7, 8'd8}, 32'h14151617, 4'b1111, 1'b1, 16'd1));
        for (int i = 1; i <= 8; i++) begin
            send_pair(8'(i), 8'(8'h0F + i), i == 8, w);
            check("t1_in_ready", W'(w), W'(0));
            if (i == 4) check("t1_latency", W'(out_valid), W'(1));
        end
        drain("t1");

        // six pairs, short padded second group
        exp_q.push_back(grp({8'd1, 8'd2, 8'd3, 8'd4}, 32'h20212223, 4'b1111, 1'b0, 16'd0));
        exp_q.push_back(grp({8'd5, 8'd6, PAD, PAD}, {8'h24, 8'h25, PAD, PAD}, 4'b0011, 1'b1, 16'd1));
        for (int i = 1; i <= 6; i++) send_pair(8'(i), 8'(8'h1F + i), i == 6, w);
        drain("t2");

        // back-pressure: second group parks in HOLD
        out_ready = 1'b0;
        g0 = grp({8'd1, 8'd2, 8'd3, 8'd4}, 32'h10111213, 4'b1111, 1'b0, 16'd0);
        g1 = grp({8'd5, 8'd6, 8'd7, 8'd8}, 32'h14151617, 4'b1111, 1'b1, 16'd1);
        exp_q.push_back(g0);
        exp_q.push_back(g1);
        for (int i = 1; i <= 8; i++) begin
            send_pair(8'(i), 8'(8'h0F + i), i == 8, w);
            check("t3_no_wait", W'(w), W'(0));
        end
        @(negedge clk);
        check("t3_hold_ready", W'(in_ready), W'(0));
        check("t3_hold_valid", W'(out_valid), W'(1));
        check("t3_hold_group0", obs, g0);
        repeat (3) @(negedge clk);
        check("t3_still_group0", obs, g0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_first", obs, g0);
        @(negedge clk);
        check("t3_consec_valid", W'(out_valid), W'(1));
        check("t3_consec_group1", obs, g1);
        check("t3_ready_back", W'(in_ready), W'(1));
        drain("t3");

        // reset in the middle of a group, with a pair on offer at the reset edge
        send_pair(8'h21, 8'h31, 1'b0, w);
        send_pair(8'h22, 8'h32, 1'b0, w);
        in_valid = 1'b1;
        in_ifm = 8'h63;
        in_wgt = 8'h73;
        in_last = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_rst_valid", W'(out_valid), W'(0));
        check("t4_rst_ready", W'(in_ready), W'(1));
        check("t4_rst_payload", obs, W'(0));
        @(posedge clk);
        #1;
        exp_q.push_back(grp({8'd9, 8'd10, 8'd11, 8'd12}, 32'h40414243, 4'b1111, 1'b1, 16'd0));
        for (int i = 0; i < 4; i++) send_pair(8'(9 + i), 8'(8'h40 + i), i == 3, w);
        drain("t4");

        // single-pair vectors
        for (int i = 0; i < 3; i++)
            exp_q.push_back(grp({8'(8'h51 + i), PAD, PAD, PAD}, {8'(8'h61 + i), PAD, PAD, PAD},
                                4'b0001, 1'b1, 16'd0));
        for (int i = 0; i < 3; i++) send_pair(8'(8'h51 + i), 8'(8'h61 + i), 1'b1, w);
        drain("t5");

        // random valid/ready stream against the packing model
        use_model = 1;
        rand_ord = 1;
        m_idx = 0;
        m_cnt = 16'd0;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) begin
                in_ifm = 8'($urandom);
                in_wgt = 8'($urandom);
                in_last = 1'($urandom);
                @(posedge clk);
                #1;
                out_ready = 1'($urandom_range(0, 1));
            end
            l = (i == 199) || ($urandom_range(0, 5) == 0);
            send_pair(8'($urandom), 8'($urandom), l, w);
        end
        rand_ord = 0;
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
